// File: rtl/fpu_double.sv
// fpu_double: IEEE-754 binary64 add/sub/mul, plus div when FPU_DIV_EN is defined; 4 rounding modes, flush-to-zero.
// Latency: ADD_LAT cycles for add/sub/mul/reserved, DIV_LAT cycles for div; one operation in flight.
// Handshake: enable accepted in IDLE/DONE (restart from DONE needs enable low since acceptance); ignored while BUSY.
module fpu_double #(
  parameter int ADD_LAT = 4,
  parameter int DIV_LAT = 60
) (
  input  logic        clk_operation,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  rmode,
  input  logic [2:0]  fpu_op,
  input  logic [63:0] opa,
  input  logic [63:0] opb,
  output logic [63:0] out,
  output logic        ready,
  output logic        underflow,
  output logic        overflow,
  output logic        inexact,
  output logic        exception,
  output logic        invalid
);
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [63:0] r_opa, r_opb;
  logic [2:0]  r_op;
  logic [1:0]  r_rmode;
  logic [5:0]  r_cnt;
  logic        r_en_low;
  logic        w_start, w_last, w_div_op;
  logic [5:0]  w_lat_m1;

  // Operand classification; denormals (exponent 0) count as zero.
  logic [10:0] w_ea, w_eb;
  logic [52:0] w_ma, w_mb;
  logic        w_sa, w_sb, w_sbe, w_za, w_zb, w_ia, w_ib, w_na, w_nb;
  assign w_ea  = r_opa[62:52];
  assign w_eb  = r_opb[62:52];
  assign w_ma  = {1'b1, r_opa[51:0]};
  assign w_mb  = {1'b1, r_opb[51:0]};
  assign w_sa  = r_opa[63];
  assign w_sb  = r_opb[63];
  assign w_sbe = r_opb[63] ^ (r_op == 3'b001);
  assign w_za  = (w_ea == 11'd0);
  assign w_zb  = (w_eb == 11'd0);
  assign w_ia  = (w_ea == 11'h7FF) && (r_opa[51:0] == 52'd0);
  assign w_ib  = (w_eb == 11'h7FF) && (r_opb[51:0] == 52'd0);
  assign w_na  = (w_ea == 11'h7FF) && (r_opa[51:0] != 52'd0);
  assign w_nb  = (w_eb == 11'h7FF) && (r_opb[51:0] != 52'd0);

`ifdef FPU_DIV_EN
  assign w_div_op = (r_op == 3'b011);
`else
  assign w_div_op = 1'b0;
`endif
  assign w_lat_m1 = w_div_op ? 6'(DIV_LAT - 1) : 6'(ADD_LAT - 1);
  assign w_start  = enable && ((r_state == S_IDLE) || ((r_state == S_DONE) && r_en_low));
  assign w_last   = (r_state == S_BUSY) && (r_cnt == w_lat_m1);

  // State register.
  always_ff @(posedge clk_operation) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: start from IDLE/DONE, finish after the op latency.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  if (w_start) w_state_nxt = S_BUSY;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Add/sub: align smaller magnitude (3 extra bits, sticky folded into LSB), add/subtract, normalise.
  logic        w_swap, w_sl, w_effsub, w_far;
  logic [10:0] w_el, w_d;
  logic [52:0] w_ml, w_ms;
  logic [108:0] w_sh;
  logic [55:0] w_al, w_norm;
  logic [56:0] w_sum;
  logic [5:0]  w_lz;
  always_comb begin
    w_swap   = r_opb[62:0] > r_opa[62:0];
    w_el     = w_swap ? w_eb : w_ea;
    w_d      = w_swap ? (w_eb - w_ea) : (w_ea - w_eb);
    w_ml     = w_swap ? w_mb : w_ma;
    w_ms     = w_swap ? w_ma : w_mb;
    w_sl     = w_swap ? w_sbe : w_sa;
    w_effsub = w_sa ^ w_sbe;
    w_far    = w_d > 11'd56;
    w_sh     = {w_ms, 56'd0} >> w_d;
    w_al     = w_far ? 56'd0 : w_sh[108:53];
    w_al[0]  = w_al[0] | w_far | (|w_sh[52:0]);
    w_sum    = w_effsub ? ({1'b0, w_ml, 3'b000} - {1'b0, w_al})
                        : ({1'b0, w_ml, 3'b000} + {1'b0, w_al});
    w_lz     = 6'd0;
    for (int i = 0; i < 56; i++) if (w_sum[i]) w_lz = 6'(55 - i);
    w_norm   = w_sum[55:0] << w_lz;
  end

  logic [105:0] w_prod;
  assign w_prod = w_ma * w_mb;

`ifdef FPU_DIV_EN
  logic [53:0] r_rem;
  logic [54:0] r_q;
  logic [52:0] w_rem_sub;
  assign w_rem_sub = r_rem[52:0] - w_mb;
  // Restoring division: one quotient bit per BUSY cycle for the first 55 cycles.
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      r_rem <= 54'd0;
      r_q   <= 55'd0;
    end else if (w_start) begin
      r_rem <= {2'b01, opa[51:0]};
      r_q   <= 55'd0;
    end else if ((r_state == S_BUSY) && (r_cnt < 6'd55)) begin
      if (r_rem >= {1'b0, w_mb}) begin
        r_rem <= {w_rem_sub, 1'b0};
        r_q   <= {r_q[53:0], 1'b1};
      end else begin
        r_rem <= {r_rem[52:0], 1'b0};
        r_q   <= {r_q[53:0], 1'b0};
      end
    end
  end
`endif

  // Pick the unrounded sign/exponent/mantissa/guard/sticky for the op, then round per rmode.
  logic               w_s, w_g, w_st, w_inc;
  logic signed [12:0] w_e, w_er;
  logic [52:0]        w_m;
  logic [53:0]        w_mr;
  logic [51:0]        w_frac;
  always_comb begin
    w_s = 1'b0; w_e = 13'sd0; w_m = 53'd0; w_g = 1'b0; w_st = 1'b0; w_inc = 1'b0;
    if (r_op == 3'b010) begin
      w_s = w_sa ^ w_sb;
      if (w_prod[105]) begin
        w_m = w_prod[105:53]; w_g = w_prod[52]; w_st = |w_prod[51:0];
      end else begin
        w_m = w_prod[104:52]; w_g = w_prod[51]; w_st = |w_prod[50:0];
      end
      w_e = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 13'sd1023
            + $signed({12'd0, w_prod[105]});
    end
`ifdef FPU_DIV_EN
    else if (w_div_op) begin
      w_s = w_sa ^ w_sb;
      if (r_q[54]) begin
        w_m = r_q[54:2]; w_g = r_q[1]; w_st = r_q[0] | (r_rem != 54'd0);
      end else begin
        w_m = r_q[53:1]; w_g = r_q[0]; w_st = (r_rem != 54'd0);
      end
      w_e = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 13'sd1023
            - $signed({12'd0, ~r_q[54]});
    end
`endif
    else begin
      w_s = w_sl;
      if (w_sum[56]) begin
        w_m = w_sum[56:4]; w_g = w_sum[3]; w_st = |w_sum[2:0];
      end else begin
        w_m = w_norm[55:3]; w_g = w_norm[2]; w_st = |w_norm[1:0];
      end
      w_e = $signed({2'b00, w_el}) + $signed({12'd0, w_sum[56]}) - $signed({7'd0, w_lz});
    end
    case (r_rmode)
      2'b00:   w_inc = w_g & (w_st | w_m[0]);
      2'b01:   w_inc = 1'b0;
      2'b10:   w_inc = ~w_s & (w_g | w_st);
      default: w_inc = w_s & (w_g | w_st);
    endcase
    w_mr   = {1'b0, w_m} + {53'd0, w_inc};
    w_er   = w_e + $signed({12'd0, w_mr[53]});
    w_frac = w_mr[53] ? w_mr[52:1] : w_mr[51:0];
  end

  // Pack the rounded result with overflow / flush-to-zero handling.
  logic [63:0] w_out;
  logic        w_of, w_uf, w_nx;
  always_comb begin
    w_of = 1'b0; w_uf = 1'b0; w_nx = 1'b0; w_out = 64'd0;
    if (w_er >= 13'sd2047) begin
      w_of = 1'b1; w_nx = 1'b1;
      if ((r_rmode == 2'b00) || ((r_rmode == 2'b10) && !w_s) || ((r_rmode == 2'b11) && w_s))
        w_out = {w_s, 11'h7FF, 52'd0};
      else
        w_out = {w_s, 63'h7FEF_FFFF_FFFF_FFFF};
    end else if (w_er <= 13'sd0) begin
      w_uf = 1'b1; w_nx = 1'b1; w_out = {w_s, 63'd0};
    end else begin
      w_out = {w_s, w_er[10:0], w_frac};
      w_nx  = w_g | w_st;
    end
  end

  // Special operands (NaN, inf, zero, reserved op, exact cancellation) bypass rounding.
  logic        w_spc, w_spc_iv, w_spc_dz;
  logic [63:0] w_spc_out;
  always_comb begin
    w_spc = 1'b1; w_spc_out = QNAN; w_spc_iv = 1'b1; w_spc_dz = 1'b0;
    if (r_op[2] || ((r_op == 3'b011) && !w_div_op)) begin
    end else if (r_op == 3'b010) begin
      if (w_na || w_nb || (w_ia && w_zb) || (w_za && w_ib)) begin
      end else if (w_ia || w_ib) begin
        w_spc_iv = 1'b0; w_spc_out = {w_sa ^ w_sb, 11'h7FF, 52'd0};
      end else if (w_za || w_zb) begin
        w_spc_iv = 1'b0; w_spc_out = {w_sa ^ w_sb, 63'd0};
      end else w_spc = 1'b0;
    end else if (w_div_op) begin
      if (w_na || w_nb || (w_za && w_zb) || (w_ia && w_ib)) begin
      end else if (w_ia || w_zb) begin
        w_spc_iv = 1'b0; w_spc_dz = w_zb; w_spc_out = {w_sa ^ w_sb, 11'h7FF, 52'd0};
      end else if (w_za || w_ib) begin
        w_spc_iv = 1'b0; w_spc_out = {w_sa ^ w_sb, 63'd0};
      end else w_spc = 1'b0;
    end else begin
      w_spc_iv = 1'b0;
      if (w_na || w_nb || (w_ia && w_ib && (w_sa != w_sbe))) w_spc_iv = 1'b1;
      else if (w_ia)              w_spc_out = {w_sa, 11'h7FF, 52'd0};
      else if (w_ib)              w_spc_out = {w_sbe, 11'h7FF, 52'd0};
      else if (w_za && w_zb)      w_spc_out = {(w_sa == w_sbe) ? w_sa : (r_rmode == 2'b11), 63'd0};
      else if (w_za)              w_spc_out = {w_sbe, r_opb[62:0]};
      else if (w_zb)              w_spc_out = r_opa;
      else if (w_sum == 57'd0)    w_spc_out = {(r_rmode == 2'b11), 63'd0};
      else                        w_spc = 1'b0;
    end
  end

  // Accept operands, count latency, write result and flags together with ready.
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      r_opa <= 64'd0; r_opb <= 64'd0; r_op <= 3'd0; r_rmode <= 2'd0;
      r_cnt <= 6'd0; r_en_low <= 1'b0;
      out <= 64'd0; ready <= 1'b0;
      underflow <= 1'b0; overflow <= 1'b0; inexact <= 1'b0; exception <= 1'b0; invalid <= 1'b0;
    end else begin
      if (!enable) r_en_low <= 1'b1;
      if (w_start) begin
        r_opa <= opa; r_opb <= opb; r_op <= fpu_op; r_rmode <= rmode;
        r_cnt <= 6'd0; r_en_low <= 1'b0; ready <= 1'b0;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 6'd1;
        if (w_last) begin
          ready     <= 1'b1;
          out       <= w_spc ? w_spc_out : w_out;
          invalid   <= w_spc & w_spc_iv;
          overflow  <= ~w_spc & w_of;
          underflow <= ~w_spc & w_uf;
          inexact   <= ~w_spc & w_nx;
          exception <= w_spc ? (w_spc_iv | w_spc_dz) : (w_of | w_uf);
        end
      end
    end
  end
endmodule

// File: tb/tb_fpu_double.sv
// tb_fpu_double: directed vector table for fpu_double plus held-enable and mid-op reset sequences.
// Expected div results depend on whether FPU_DIV_EN is defined for the build.
module tb_fpu_double;
  logic        clk_operation = 1'b0;
  logic        rst, enable;
  logic [1:0]  rmode;
  logic [2:0]  fpu_op;
  logic [63:0] opa, opb, out;
  logic        ready, underflow, overflow, inexact, exception, invalid;
  int checks = 0;
  int errors = 0;

  localparam logic [4:0] F_UF = 5'b10000, F_OF = 5'b01000, F_NX = 5'b00100,
                         F_EX = 5'b00010, F_IV = 5'b00001;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  fpu_double dut (
    .clk_operation(clk_operation), .rst(rst), .enable(enable), .rmode(rmode), .fpu_op(fpu_op),
    .opa(opa), .opb(opb), .out(out), .ready(ready), .underflow(underflow), .overflow(overflow),
    .inexact(inexact), .exception(exception), .invalid(invalid)
  );

  always #5 clk_operation = ~clk_operation;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  rm;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [4:0]  fl;
    int          lat;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(negedge clk_operation);
    opa = v.a; opb = v.b; fpu_op = v.op; rmode = v.rm; enable = 1'b1;
    @(negedge clk_operation);
    enable = 1'b0; opa = ~v.a; opb = ~v.b; fpu_op = 3'b000; rmode = ~v.rm;
    chk($sformatf("v%0d ready_cleared", idx), {63'd0, ready}, 64'd0);
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk_operation);
      n++;
    end
    chk($sformatf("v%0d latency", idx), 64'(n), 64'(v.lat));
    chk($sformatf("v%0d out", idx), out, v.res);
    chk($sformatf("v%0d flags(uf,of,nx,ex,iv)", idx),
        {59'd0, underflow, overflow, inexact, exception, invalid}, {59'd0, v.fl});
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 1'b0; rmode = 2'b00; fpu_op = 3'b000; opa = 64'd0; opb = 64'd0;
    repeat (3) @(negedge clk_operation);
    chk("reset out", out, 64'd0);
    chk("reset ready", {63'd0, ready}, 64'd0);
    chk("reset flags", {59'd0, underflow, overflow, inexact, exception, invalid}, 64'd0);
    rst = 1'b0;

    vt.push_back('{3'b010, 2'b00, 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b0, 4});
    vt.push_back('{3'b000, 2'b00, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b0, 4});
    vt.push_back('{3'b001, 2'b00, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 5'b0, 4});
    vt.push_back('{3'b001, 2'b11, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h8000000000000000, 5'b0, 4});
    vt.push_back('{3'b010, 2'b00, 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 64'h7FF0000000000000, F_OF|F_NX|F_EX, 4});
    vt.push_back('{3'b010, 2'b01, 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 64'h7FEFFFFFFFFFFFFF, F_OF|F_NX|F_EX, 4});
    vt.push_back('{3'b010, 2'b11, 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 64'h7FEFFFFFFFFFFFFF, F_OF|F_NX|F_EX, 4});
    vt.push_back('{3'b010, 2'b10, 64'hFFEFFFFFFFFFFFFF, 64'h4000000000000000, 64'hFFEFFFFFFFFFFFFF, F_OF|F_NX|F_EX, 4});
    vt.push_back('{3'b010, 2'b11, 64'hFFEFFFFFFFFFFFFF, 64'h4000000000000000, 64'hFFF0000000000000, F_OF|F_NX|F_EX, 4});
    vt.push_back('{3'b010, 2'b00, 64'h0000000000000000, 64'h7FF0000000000000, QNAN, F_EX|F_IV, 4});
    vt.push_back('{3'b010, 2'b00, 64'hBFF8000000000000, 64'h4000000000000000, 64'hC008000000000000, 5'b0, 4});
    vt.push_back('{3'b010, 2'b00, 64'h1A70000000000000, 64'h1A70000000000000, 64'h0000000000000000, F_UF|F_NX|F_EX, 4});
    vt.push_back('{3'b000, 2'b00, 64'h3FF0000000000000, 64'h3CA0000000000000, 64'h3FF0000000000000, F_NX, 4});
    vt.push_back('{3'b000, 2'b10, 64'h3FF0000000000000, 64'h3CA0000000000000, 64'h3FF0000000000001, F_NX, 4});
    vt.push_back('{3'b000, 2'b00, 64'h3FF0000000000000, 64'h3CA0000000000001, 64'h3FF0000000000001, F_NX, 4});
    vt.push_back('{3'b000, 2'b00, 64'h3FFFFFFFFFFFFFFF, 64'h3CA0000000000000, 64'h4000000000000000, F_NX, 4});
    vt.push_back('{3'b001, 2'b00, 64'h3FF0000000000000, 64'h3CA0000000000000, 64'h3FEFFFFFFFFFFFFF, 5'b0, 4});
    vt.push_back('{3'b001, 2'b00, 64'h4000000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000, 5'b0, 4});
    vt.push_back('{3'b000, 2'b00, 64'h0000000000000001, 64'h3FF0000000000000, 64'h3FF0000000000000, 5'b0, 4});
    vt.push_back('{3'b000, 2'b00, 64'h7FF0000000000000, 64'hFFF0000000000000, QNAN, F_EX|F_IV, 4});
    vt.push_back('{3'b000, 2'b00, 64'h7FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000, 5'b0, 4});
    vt.push_back('{3'b000, 2'b00, 64'h7FF0000000000001, 64'h3FF0000000000000, QNAN, F_EX|F_IV, 4});
    vt.push_back('{3'b000, 2'b00, 64'h8000000000000000, 64'h8000000000000000, 64'h8000000000000000, 5'b0, 4});
    vt.push_back('{3'b100, 2'b00, 64'h3FF0000000000000, 64'h3FF0000000000000, QNAN, F_EX|F_IV, 4});
`ifdef FPU_DIV_EN
    vt.push_back('{3'b011, 2'b00, 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, F_NX, 60});
    vt.push_back('{3'b011, 2'b00, 64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, F_EX, 60});
    vt.push_back('{3'b011, 2'b00, 64'h4018000000000000, 64'h4008000000000000, 64'h4000000000000000, 5'b0, 60});
`else
    vt.push_back('{3'b011, 2'b00, 64'h3FF0000000000000, 64'h4008000000000000, QNAN, F_EX|F_IV, 4});
`endif

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

    // enable held through completion: a single op, no re-trigger while held
    @(negedge clk_operation);
    opa = 64'h3FF8000000000000; opb = 64'h4000000000000000; fpu_op = 3'b010; rmode = 2'b00;
    enable = 1'b1;
    repeat (12) @(negedge clk_operation);
    chk("held ready stays", {63'd0, ready}, 64'd1);
    chk("held out", out, 64'h4008000000000000);
    enable = 1'b0;
    @(negedge clk_operation);
    opa = 64'h3FF0000000000000; enable = 1'b1;
    @(negedge clk_operation);
    enable = 1'b0;
    chk("restart ready cleared", {63'd0, ready}, 64'd0);
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk_operation);
      n++;
    end
    chk("restart latency", 64'(n), 64'd4);
    chk("restart out", out, 64'h4000000000000000);

    // reset in the middle of an operation
    @(negedge clk_operation);
    opa = 64'h3FF8000000000000; opb = 64'h4000000000000000; fpu_op = 3'b010; enable = 1'b1;
    @(negedge clk_operation);
    enable = 1'b0;
    @(negedge clk_operation);
    rst = 1'b1;
    @(negedge clk_operation);
    rst = 1'b0;
    chk("midreset ready", {63'd0, ready}, 64'd0);
    chk("midreset out", out, 64'd0);
    chk("midreset flags", {59'd0, underflow, overflow, inexact, exception, invalid}, 64'd0);
    repeat (8) @(negedge clk_operation);
    chk("midreset no late ready", {63'd0, ready}, 64'd0);
    run_vec(vt[4], 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
